// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode overlay: screen geometry,
// FSM encoding and the pixel-pipeline sideband bundle.
package vga_text_pkg;

    localparam int unsigned COLS      = 80;
    localparam int unsigned ROWS      = 30;
    localparam int unsigned CELLS     = 2400;
    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned CHAR_H    = 16;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned CHAR_BITS = 7;
    localparam logic [6:0]  SPACE     = 7'h20;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Per-pixel sidebands that travel alongside the buffer/ROM lookups.
    typedef struct packed {
        logic       vld;
        logic       von;
        logic       hs;
        logic       vs;
        logic       cur;
        logic [2:0] xoff;
    } side_t;

    localparam side_t SIDE_RST = '{vld: 1'b0, von: 1'b0, hs: 1'b1, vs: 1'b1,
                                   cur: 1'b0, xoff: 3'd0};

    // row*80 + col without a multiplier.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                    input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/text_overlay_gen_if.sv
// Host-side port of the text overlay: character-buffer write handshake and
// cursor position.
interface text_overlay_gen_if;
    import vga_text_pkg::*;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [CHAR_BITS-1:0] wr_char;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    cursor_addr;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_char,
        output cursor_addr,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_char,
        input  cursor_addr,
        output wr_ready
    );

endinterface

// File: rtl/text_overlay_gen_font_rom.sv
// 2048x8 synchronous-read font ROM, address {char[6:0], glyph_row[3:0]}.
// Row 0 is the top scanline; bit 7 of each row is the leftmost pixel.
module font_rom_8x16 (
    input  logic        clk,
    input  logic        en,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [127:0] w_glyph;
    logic [3:0]   w_row_inv;

    // Glyphs not listed here (including space) render as an empty cell.
    always_comb begin
        w_glyph = '0;
        case (addr[10:4])
            7'h30:   w_glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            7'h31:   w_glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            7'h41:   w_glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            7'h42:   w_glyph = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
            7'h48:   w_glyph = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
            7'h49:   w_glyph = 128'h0000_3C18_1818_1818_1818_183C_0000_0000;
            7'h4F:   w_glyph = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
            7'h5A:   w_glyph = 128'h0000_FEC6_860C_1830_60C2_C6FE_0000_0000;
            7'h7F:   w_glyph = {128{1'b1}};
            default: w_glyph = '0;
        endcase
    end

    assign w_row_inv = 4'd15 - addr[3:0];

    always_ff @(posedge clk) begin
        if (en) begin
            data <= w_glyph[{w_row_inv, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/text_overlay_gen.sv
// Text-mode pixel generator: 80x30 cells of 8x16 glyphs from an internal
// character buffer, with a blinking inverted cursor and delay-matched syncs.
module text_overlay_gen
    import vga_text_pkg::*;
#(
    parameter int unsigned largo     = 10,
    parameter logic [11:0] FG        = 12'h0F0,
    parameter logic [11:0] BG        = 12'h000,
    parameter int unsigned BLINK_BIT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_tick,
    input  logic             video_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [largo-1:0] pixel_x,
    input  logic [largo-1:0] pixel_y,
    text_overlay_gen_if.slave host,
    output logic [11:0]      rgb,
    output logic             hsync,
    output logic             vsync
);

    state_e               r_state;
    logic [ADDR_W-1:0]    r_clr_cnt;
    logic                 r_wr_ready;

    logic                 w_we;
    logic [ADDR_W-1:0]    w_waddr;
    logic [CHAR_BITS-1:0] w_wdata;

    logic [CHAR_BITS-1:0] r_mem [4096];

    logic [ADDR_W-1:0]    w_addr;
    logic                 w_unused_y;

    side_t                r_s1, r_s2, r_s3;
    logic [ADDR_W-1:0]    r_addr_s1;
    logic [3:0]           r_yoff_s1, r_yoff_s2;
    logic [CHAR_BITS-1:0] r_char_s2;
    logic [7:0]           w_rom_data;

    logic [5:0]           r_frame;
    logic                 r_vs_prev;

    logic                 w_bit;
    logic                 w_on;

    // Buffer-fill FSM; CLEAR walks every cell once, then hands the port to the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_cnt  <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_W'(CELLS - 1)) begin
                        r_state    <= RUN;
                        r_wr_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_wr_ready <= 1'b1;
                end
                default: begin
                    r_state    <= CLEAR;
                    r_clr_cnt  <= '0;
                    r_wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign host.wr_ready = r_wr_ready;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_cnt;
        w_wdata = SPACE;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (host.wr_en && r_wr_ready && (host.wr_addr < ADDR_W'(CELLS))) begin
            w_we    = 1'b1;
            w_waddr = host.wr_addr;
            w_wdata = host.wr_char;
        end
    end

    // Read-before-write: a same-cycle read of the written cell returns old data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (p_tick) begin
            r_char_s2 <= r_mem[r_addr_s1];
        end
    end

    assign w_addr     = cell_addr(pixel_y[8:4], pixel_x[9:3]);
    assign w_unused_y = ^pixel_y[largo-1:9];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= SIDE_RST;
            r_s2      <= SIDE_RST;
            r_s3      <= SIDE_RST;
            r_addr_s1 <= '0;
            r_yoff_s1 <= '0;
            r_yoff_s2 <= '0;
        end else if (p_tick) begin
            r_s1      <= '{vld:  (r_state == RUN),
                           von:  video_on,
                           hs:   hsync_in,
                           vs:   vsync_in,
                           cur:  (w_addr == host.cursor_addr),
                           xoff: pixel_x[2:0]};
            r_addr_s1 <= w_addr;
            r_yoff_s1 <= pixel_y[3:0];
            r_s2      <= r_s1;
            r_yoff_s2 <= r_yoff_s1;
            r_s3      <= r_s2;
        end
    end

    font_rom_8x16 u_font_rom (
        .clk  (clk),
        .en   (p_tick),
        .addr ({r_char_s2, r_yoff_s2}),
        .data (w_rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame   <= '0;
            r_vs_prev <= 1'b1;
        end else if (p_tick) begin
            r_vs_prev <= vsync_in;
            if (r_vs_prev && !vsync_in) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    // Invalid stages cover both reset and the CLEAR sweep, so rgb stays black there.
    always_comb begin
        w_bit = w_rom_data[3'd7 - r_s3.xoff];
        w_on  = w_bit ^ (r_s3.cur & r_frame[BLINK_BIT]);
        rgb   = (!r_s3.vld || !r_s3.von) ? 12'h000 : (w_on ? FG : BG);
    end

    assign hsync = r_s3.hs;
    assign vsync = r_s3.vs;

endmodule

// File: doc/text_overlay_gen.md
# text_overlay_gen

Text-mode pixel generator that sits directly downstream of the VGA sync generator. It consumes `pixel_x`, `pixel_y`, `video_on`, `p_tick` and the raw sync pulses, and renders an 80×30 grid of 8×16 glyphs from an internal character buffer. It emits 12-bit RGB plus syncs, delayed to stay pixel-aligned with the RGB. A host-side write port fills the buffer, and a blinking inverted cursor marks one cell.

## Interface
- `largo`, 10: width of `pixel_x` and `pixel_y`.
- `FG`, 12'h0F0: foreground RGB (4:4:4).
- `BG`, 12'h000: background RGB.
- `BLINK_BIT`, 5: frame-counter bit that drives cursor visibility (toggles every 32 frames).

Ports:
- `clk`  in  1  system clock; the same clock the sync generator runs on.
- `rst`  in  1  synchronous, active-high reset.
- `p_tick`  in  1  pixel enable, one `clk` wide, at 25 MHz.
- `video_on`  in  1  visible-area flag from the sync generator.
- `hsync_in`, `vsync_in`  in  1  sync pulses from the sync generator (active low).
- `pixel_x`, `pixel_y`  in  largo  current pixel coordinates.
- `wr_en`  in  1  write request.
- `wr_addr`  in  12  cell index, row*80+col, valid range 0..2399.
- `wr_char`  in  7  ASCII code.
- `wr_ready`  out  1  write port can accept.
- `cursor_addr`  in  12  cell index of the cursor; values ≥2400 mean no cursor.
- `rgb`  out  12  pixel colour.
- `hsync`, `vsync`  out  1  syncs delayed to match `rgb`.

## Operation
- **Reset values:** `rgb`=0, `hsync`=1, `vsync`=1, `wr_ready`=0. The FSM enters CLEAR with clear counter 0, the frame counter is 0, and all pipeline valid bits are 0.
- **FSM CLEAR:**
  - Writes 7'h20 (space) to cell `clr_cnt` every `clk` and increments the counter.
  - At `clr_cnt`==2399 it writes that cell and moves to RUN next cycle, so CLEAR lasts exactly 2400 cycles.
  - `wr_ready`=0, and `rgb` is forced to 0 (syncs still pass through).
- **FSM RUN:**
  - `wr_ready`=1.
  - A write occurs on any cycle with `wr_en`&`wr_ready`.
  - When `wr_addr`≥2400 the write is accepted but dropped. Addresses do not wrap.
- **`rst` asserted mid-operation**, in either state, restarts CLEAR from cell 0.
- **Cell address:** `row`=`pixel_y`[8:4] (0..29), `col`=`pixel_x`[9:3] (0..79). `addr`=(row<<6)+(row<<4)+col, 12 bits unsigned.
- **Pipeline** (advances only on `clk` edges where `p_tick`=1):
  - S1: register `addr`, `pixel_x`[2:0], `pixel_y`[3:0], `video_on`, `hsync_in`, `vsync_in`, and a cursor-hit flag (`addr`==`cursor_addr`).
  - S2: synchronous buffer read at the S1 address; carry the sidebands forward.
  - S3: font ROM read at {char, glyph row}; carry the sidebands forward.
  - Output stage: select bit = `rom_data`[7 − x_off] (bit 7 is the leftmost pixel).
    - `on` = bit XOR (cursor_hit & frame_cnt[BLINK_BIT]).
    - `rgb` = !video_on_d ? 0 : (on ? FG : BG).
- **Frame counter:** 6 bits. Increments once per falling edge of `vsync_in`, sampled on `p_tick`. Wraps 63→0.
- **Buffer ports:** one write port (shared by CLEAR and host writes via a mux) and one read port. Same-address write and read in the same cycle returns the old data.

## Timing
- Pixel latency from inputs to `rgb`/`hsync`/`vsync` is exactly 3 `p_tick` periods. Syncs pass through the same number of stages, so they stay aligned with `rgb`.
- Outputs change only on `clk` edges where `p_tick`=1, and hold between ticks.
- A host write in cycle N is visible to a pixel fetch whose S2 read occurs in cycle N+1 or later.
- `wr_ready` rises on the first RUN cycle, 2400 `clk` cycles after `rst` deasserts.
- The cursor toggles on frame_cnt[5], i.e. every 32 vsync pulses.

## Structure
- **Shared package `vga_text_pkg`:**
  - constants COLS=80, ROWS=30, CELLS=2400, CHAR_W=8, CHAR_H=16, SPACE=7'h20;
  - the 1-bit FSM state encoding (CLEAR=0, RUN=1).
- **Sub-module `font_rom_8x16`:** synchronous-read ROM, 2048×8, address {char[6:0], row[3:0]}, with `clk`, `en`, `addr[10:0]`, `data[7:0]`.
- The character buffer is inferred block RAM, 2400×7 (4096 deep), inside the block.

## Test plan
- **Reset and clear:** pulse `rst` 1 cycle → `wr_ready`=0 for 2400 cycles then 1. Reading all cells by rendering yields blank BG (space glyph), and `rgb`=0 throughout CLEAR.
- **Latency and alignment:** drive the sync generator with the buffer empty → `hsync` falling edge occurs exactly 3 `p_tick`s after `hsync_in` falls. `rgb`=0 whenever the `video_on` from 3 ticks earlier was 0.
- **Glyph render:** write 7'h41 ('A') to cell 0 → pixels (0..7, 0..15) match the ROM rows for 'A' in FG/BG. Pixel (8,0) is BG.
- **Address arithmetic:** write 'Z' to cell 2399 → the glyph appears at pixel_x 632..639, pixel_y 464..479. A write to `wr_addr`=2400 changes no visible pixel.
- **Cursor blink:** `cursor_addr`=81, cell 81 = space → cell (row 1, col 1) is BG for frames 0–31 and all FG for frames 32–63. `cursor_addr`=4095 → no inversion.
- **Reset mid-run:** assert `rst` while in RUN with written text → `wr_ready` drops next cycle, and after 2400 cycles the screen is blank again.
